id_hazard_unit: RTL and testbench

Parametrised ID-stage hazard unit. It resolves register operands for up to NSRC sources against NSTAGE downstream producer stages, and generates forward selects and a stall. It also tracks one in-flight multi-cycle MDU operation (mult/div) with a countdown FSM that interlocks HI/LO accesses. It sits beside the decoder in ID, drives the operand muxes and the IF/ID hold, and provides a stall performance counter and a stall watchdog.

---
 rtl/id_hazard_unit.sv | 131 +++++++++++++
 tb/tb_id_hazard_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_unit.sv
// ID-stage hazard unit: operand forwarding selects, load-use and MDU interlock stalls,
// a single in-flight MDU countdown, a saturating stall counter and a stall watchdog.
module id_hazard_unit #(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned SELW   = $clog2(NSTAGE + 1),
  parameter int unsigned LATW   = 6,
  parameter int unsigned TMO    = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   sweap,
  input  logic                   id_valid,
  input  logic [NSRC-1:0]        id_src_en,
  input  logic [NSRC*5-1:0]      id_src,
  input  logic                   id_uses_hilo,
  input  logic                   id_mdu_start,
  input  logic [LATW-1:0]        id_mdu_lat,
  input  logic                   mdu_done,
  input  logic [NSTAGE-1:0]      st_wen,
  input  logic [NSTAGE*5-1:0]    st_dest,
  input  logic [NSTAGE-1:0]      st_rdy,
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   mdu_busy,
  output logic [31:0]            stall_cycles,
  output logic                   hazard_err
);

  localparam int unsigned RUNW = $clog2(TMO + 1);
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [NSRC-1:0]            src_hit;
  logic [NSRC-1:0]            src_rdy;
  logic [NSRC-1:0][SELW-1:0]  src_sel;
  logic                       data_stall;
  logic                       mdu_stall;
  logic                       issue;

  logic [0:0]      state_q, state_d;
  logic [LATW-1:0] cnt_q, cnt_d;
  logic [31:0]     stall_cycles_q, stall_cycles_d;
  logic [RUNW-1:0] run_q, run_d;
  logic            err_q, err_d;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    src_hit = '0;
    src_rdy = '0;
    src_sel = '0;
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (id_src_en[i] && (id_src[5*i +: 5] != 5'd0) && st_wen[k] &&
            (st_dest[5*k +: 5] == id_src[5*i +: 5])) begin
          src_hit[i] = 1'b1;
          src_rdy[i] = st_rdy[k];
          src_sel[i] = SELW'(k + 1);
        end
      end
      if (src_hit[i] && src_rdy[i]) begin
        fwd_sel[i*SELW +: SELW] = src_sel[i];
      end
    end
  end

  assign data_stall = |(src_hit & ~src_rdy);
  assign mdu_stall  = id_valid & (state_q == StBusy) & (id_uses_hilo | id_mdu_start);
  assign stall      = ~sweap & resetn & (data_stall | mdu_stall);
  assign issue      = id_valid & id_mdu_start & ~stall & ~sweap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StBusy;
          cnt_d   = (id_mdu_lat == '0) ? LATW'(1) : id_mdu_lat;
        end
      end
      StBusy: begin
        if (mdu_done || (cnt_q == LATW'(1))) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LATW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    run_d = '0;
    if (stall) begin
      run_d = (run_q == RUNW'(TMO)) ? run_q : run_q + RUNW'(1);
    end
    // This stall cycle is the TMO-th in a row when run_q already holds TMO-1.
    err_d = err_q | (stall && (run_q >= RUNW'(TMO - 1)));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      run_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      err_q          <= err_d;
    end
  end

  assign mdu_busy     = (state_q == StBusy);
  assign stall_cycles = stall_cycles_q;
  assign hazard_err   = err_q;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Bench for id_hazard_unit: directed scenarios then random traffic, checked each cycle
// against a cycle-indexed reference model.
module tb_id_hazard_unit;

  localparam int NSTAGE = 3;
  localparam int NSRC   = 2;
  localparam int SELW   = 2;
  localparam int LATW   = 6;
  localparam int TMO    = 64;

  logic                 clk = 1'b0;
  logic                 resetn, sweap, id_valid;
  logic [NSRC-1:0]      id_src_en;
  logic [NSRC*5-1:0]    id_src;
  logic                 id_uses_hilo, id_mdu_start;
  logic [LATW-1:0]      id_mdu_lat;
  logic                 mdu_done;
  logic [NSTAGE-1:0]    st_wen;
  logic [NSTAGE*5-1:0]  st_dest;
  logic [NSTAGE-1:0]    st_rdy;
  logic                 stall;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 mdu_busy;
  logic [31:0]          stall_cycles;
  logic                 hazard_err;

  id_hazard_unit #(
    .NSTAGE(NSTAGE), .NSRC(NSRC), .SELW(SELW), .LATW(LATW), .TMO(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .sweap(sweap), .id_valid(id_valid),
    .id_src_en(id_src_en), .id_src(id_src), .id_uses_hilo(id_uses_hilo),
    .id_mdu_start(id_mdu_start), .id_mdu_lat(id_mdu_lat), .mdu_done(mdu_done),
    .st_wen(st_wen), .st_dest(st_dest), .st_rdy(st_rdy), .stall(stall),
    .fwd_sel(fwd_sel), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles),
    .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: MDU is busy in every cycle index up to and including m_until.
  int          cyc     = 0;
  int          m_until = -1;
  logic [31:0] m_stalls = '0;
  int          m_run   = 0;
  logic        m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        busy, e_stall, e_issue, ds;
    logic [SELW-1:0] e_fwd [NSRC];
    logic        e_nr [NSRC];
    busy = (cyc <= m_until);
    ds = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      bit found = 0;
      e_fwd[i] = '0;
      e_nr[i]  = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && id_src_en[i] && id_src[5*i +: 5] != 0 && st_wen[k] &&
            st_dest[5*k +: 5] == id_src[5*i +: 5]) begin
          found = 1;
          if (st_rdy[k]) e_fwd[i] = SELW'(k + 1);
          else e_nr[i] = 1'b1;
        end
      end
      ds |= e_nr[i];
    end
    e_stall = resetn && !sweap && (ds || (id_valid && busy && (id_uses_hilo || id_mdu_start)));
    e_issue = id_valid && id_mdu_start && !e_stall && !sweap;
    #2;
    chk("stall", 32'(stall), 32'(e_stall));
    for (int i = 0; i < NSRC; i++) begin
      if (!e_nr[i]) chk($sformatf("fwd_sel%0d", i), 32'(fwd_sel[i*SELW +: SELW]), 32'(e_fwd[i]));
    end
    chk("mdu_busy", 32'(mdu_busy), 32'(busy));
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("hazard_err", 32'(hazard_err), 32'(m_err));
    @(posedge clk);
    if (!resetn) begin
      m_until  = cyc;
      m_stalls = '0;
      m_run    = 0;
      m_err    = 1'b0;
    end else begin
      if (busy && mdu_done) m_until = cyc;
      else if (!busy && e_issue) m_until = cyc + ((id_mdu_lat == 0) ? 1 : int'(id_mdu_lat));
      if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      m_run = e_stall ? m_run + 1 : 0;
      if (m_run >= TMO) m_err = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic quiet();
    sweap = 0; id_valid = 1; id_src_en = '0; id_src = '0; id_uses_hilo = 0;
    id_mdu_start = 0; id_mdu_lat = '0; mdu_done = 0; st_wen = '0; st_dest = '0; st_rdy = '0;
  endtask

  initial begin
    int n;
    quiet();
    resetn = 0;
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    resetn = 1;
    tick();

    // Youngest producer wins, then the older one once the younger stops writing.
    id_src_en = 2'b01; id_src[4:0] = 5'd5;
    st_wen = 3'b011; st_dest[4:0] = 5'd5; st_dest[9:5] = 5'd5; st_rdy = 3'b011;
    tick();
    st_wen = 3'b010;
    tick();

    // Load-use then forward from MEM.
    quiet();
    id_src_en = 2'b10; id_src[9:5] = 5'd7;
    st_wen = 3'b001; st_dest[4:0] = 5'd7; st_rdy = 3'b000;
    tick();
    st_wen = 3'b010; st_dest[9:5] = 5'd7; st_rdy = 3'b010;
    tick();

    // r0 and disabled source never hazard.
    quiet();
    id_src_en = 2'b01; id_src[4:0] = 5'd0; id_src[9:5] = 5'd9;
    st_wen = 3'b011; st_dest[4:0] = 5'd0; st_dest[9:5] = 5'd9;
    tick();

    // MDU latency 4 with a HI/LO consumer waiting behind it.
    quiet();
    id_mdu_start = 1; id_mdu_lat = 6'd4;
    tick();
    id_mdu_start = 0; id_uses_hilo = 1;
    n = 0;
    for (int j = 0; j < 10; j++) begin
      if (!stall) break;
      n++;
      tick();
    end
    chk("mflo_stall_len", 32'(n), 32'd4);
    tick();
    quiet();
    id_mdu_start = 1; id_mdu_lat = 6'd0;
    tick();
    quiet();
    tick();
    tick();

    // Early completion and flush-blocked issue.
    id_mdu_start = 1; id_mdu_lat = 6'd20;
    tick();
    quiet();
    tick();
    tick();
    mdu_done = 1;
    tick();
    mdu_done = 0;
    tick();
    tick();
    id_mdu_start = 1; id_mdu_lat = 6'd3; sweap = 1;
    tick();
    quiet();
    tick();
    tick();

    // Watchdog: long not-ready match.
    id_src_en = 2'b01; id_src[4:0] = 5'd3; st_wen = 3'b001; st_dest[4:0] = 5'd3;
    repeat (TMO + 6) tick();
    chk("hazard_err_set", 32'(hazard_err), 32'd1);
    quiet();
    repeat (3) tick();
    chk("hazard_err_sticky", 32'(hazard_err), 32'd1);

    // Reset in the middle of a BUSY window.
    id_mdu_start = 1; id_mdu_lat = 6'd10;
    tick();
    quiet();
    repeat (3) tick();
    resetn = 0;
    tick();
    resetn = 1;
    tick();
    chk("busy_after_reset", 32'(mdu_busy), 32'd0);
    tick();

    for (int j = 0; j < 2000; j++) begin
      resetn       = ($urandom_range(0, 59) != 0);
      sweap        = ($urandom_range(0, 9) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_src_en    = NSRC'($urandom);
      id_src[4:0]  = 5'($urandom_range(0, 3));
      id_src[9:5]  = 5'($urandom_range(0, 3));
      id_uses_hilo = ($urandom_range(0, 3) == 0);
      id_mdu_start = ($urandom_range(0, 7) == 0);
      id_mdu_lat   = LATW'($urandom_range(0, 5));
      mdu_done     = ($urandom_range(0, 5) == 0);
      st_wen       = NSTAGE'($urandom);
      st_rdy       = NSTAGE'($urandom);
      for (int k = 0; k < NSTAGE; k++) st_dest[5*k +: 5] = 5'($urandom_range(0, 3));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
